// File: rtl/dbg_host_pkg.sv
// Shared opcodes, CPU command codes, response bytes and FSM states for the host debug bridge.
package dbg_host_pkg;

   localparam logic [7:0] OP_REG_RD  = 8'h00;
   localparam logic [7:0] OP_IMEM_WR = 8'h01;
   localparam logic [7:0] OP_DMEM_RD = 8'h02;
   localparam logic [7:0] OP_DMEM_WR = 8'h03;

   localparam logic [1:0] CMD_REG_RD  = 2'b00;
   localparam logic [1:0] CMD_IMEM_WR = 2'b01;
   localparam logic [1:0] CMD_DMEM_RD = 2'b10;
   localparam logic [1:0] CMD_DMEM_WR = 2'b11;

   localparam logic [7:0] RSP_ACK = 8'hA5;
   localparam logic [7:0] RSP_ERR = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_WRITE,
      ST_RDWAIT,
      ST_RESP,
      ST_ERR
   } state_t;

   function automatic logic op_valid(input logic [7:0] op);
      return (op[7:2] == 6'd0);
   endfunction

   // Opcode low bits coincide with the CPU command encoding; odd codes are writes.
   function automatic logic [1:0] op2cmd(input logic [7:0] op);
      return op[1:0];
   endfunction

endpackage

// File: rtl/dbg_word_ser.sv
// 32-bit word to LSB-first byte serializer on a valid/ready link; sends 1..4 bytes per load.
module dbg_word_ser (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic [31:0] i_word,
   input  logic [2:0]  i_nbytes,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_last_ack
);

   logic [31:0] r_word;
   logic [2:0]  r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_word <= i_word;
         r_cnt  <= i_nbytes;
      end else if (o_tx_valid && i_tx_ready) begin
         r_word <= {8'h00, r_word[31:8]};
         r_cnt  <= r_cnt - 3'd1;
      end
   end

   assign o_tx_data  = r_word[7:0];
   assign o_tx_valid = (r_cnt != 3'd0);
   assign o_last_ack = i_tx_ready && (r_cnt == 3'd1);

endmodule

// File: rtl/dbg_host_bridge.sv
// Host byte-stream to CPU external-port bridge: OP + ADDR(4) [+ DATA(4)] frames, byte responses.
// Optional inter-byte timeout enabled by defining DBG_TIMEOUT_EN.
module dbg_host_bridge
   import dbg_host_pkg::*;
#(
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [1:0]  host_cmd,
   output logic [31:0] host_addr,
   output logic [31:0] host_data,
   input  logic [31:0] host_rdata,
   output logic        busy
);

   localparam int unsigned WW = $clog2(RD_LAT + 1) + 1;

   state_t         r_state, w_next;
   logic [1:0]     r_bcnt, r_cmd;
   logic [31:0]    r_addr, r_data;
   logic [WW-1:0]  r_wait;
   logic           w_rx_acc, w_tmo_hit, w_ser_load, w_ser_last;
   logic [31:0]    w_ser_word;
   logic [2:0]     w_ser_n;

   assign w_rx_acc  = rx_valid && rx_ready;
   assign host_addr = r_addr;
   assign host_data = r_data;
   assign busy      = (r_state != ST_IDLE);

`ifdef DBG_TIMEOUT_EN
   logic [31:0] r_tmo;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_tmo <= '0;
      else if ((r_state == ST_ADDR || r_state == ST_DATA) && !w_rx_acc)
         r_tmo <= r_tmo + 32'd1;
      else
         r_tmo <= '0;
   end

   assign w_tmo_hit = (r_tmo == TIMEOUT_CYC);
`else
   // Timeout compiled out; the parameter stays referenced so the interface is unchanged.
   assign w_tmo_hit = (TIMEOUT_CYC == 32'd0) & 1'b0;
`endif

   always_comb begin
      w_next     = r_state;
      rx_ready   = 1'b0;
      host_cmd   = CMD_REG_RD;
      w_ser_load = 1'b0;
      w_ser_word = '0;
      w_ser_n    = '0;
      case (r_state)
         ST_IDLE: begin
            rx_ready = 1'b1;
            if (w_rx_acc)
               w_next = op_valid(rx_data) ? ST_ADDR : ST_ERR;
         end
         ST_ADDR: begin
            rx_ready = 1'b1;
            if (w_rx_acc) begin
               if (r_bcnt == 2'd3)
                  w_next = r_cmd[0] ? ST_DATA : ST_RDWAIT;
            end else if (w_tmo_hit) begin
               w_next = ST_ERR;
            end
         end
         ST_DATA: begin
            rx_ready = 1'b1;
            if (w_rx_acc) begin
               if (r_bcnt == 2'd3)
                  w_next = ST_WRITE;
            end else if (w_tmo_hit) begin
               w_next = ST_ERR;
            end
         end
         ST_WRITE: begin
            host_cmd   = r_cmd;
            w_ser_load = 1'b1;
            w_ser_word = {24'h0, RSP_ACK};
            w_ser_n    = 3'd1;
            w_next     = ST_RESP;
         end
         ST_RDWAIT: begin
            // Sync-read CPU port: command held RD_LAT+1 cycles, data sampled on the last.
            host_cmd = r_cmd;
            if (r_wait == WW'(RD_LAT)) begin
               w_ser_load = 1'b1;
               w_ser_word = host_rdata;
               w_ser_n    = 3'd4;
               w_next     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (w_ser_last)
               w_next = ST_IDLE;
         end
         ST_ERR: begin
            w_ser_load = 1'b1;
            w_ser_word = {24'h0, RSP_ERR};
            w_ser_n    = 3'd1;
            w_next     = ST_RESP;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_bcnt  <= '0;
         r_cmd   <= CMD_REG_RD;
         r_addr  <= '0;
         r_data  <= '0;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= (r_state == ST_RDWAIT) ? r_wait + WW'(1) : '0;
         if (w_rx_acc) begin
            case (r_state)
               ST_IDLE: begin
                  r_cmd  <= op2cmd(rx_data);
                  r_bcnt <= '0;
               end
               ST_ADDR: begin
                  r_addr <= {rx_data, r_addr[31:8]};
                  r_bcnt <= r_bcnt + 2'd1;
               end
               ST_DATA: begin
                  r_data <= {rx_data, r_data[31:8]};
                  r_bcnt <= r_bcnt + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

   dbg_word_ser u_ser (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_ser_load),
      .i_word     (w_ser_word),
      .i_nbytes   (w_ser_n),
      .o_tx_data  (tx_data),
      .o_tx_valid (tx_valid),
      .i_tx_ready (tx_ready),
      .o_last_ack (w_ser_last)
   );

endmodule
